// File: rtl/neuron_sweep_sched_pkg.sv
// Shared types and defaults for the neuron sweep scheduler slice.
package neuron_pkg;

  localparam int NEURON_NO_DEF  = 256;
  localparam int PIPE_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    EXT_NONE = 2'd0,
    EXT_RD   = 2'd1,
    EXT_WR   = 2'd2
  } ext_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  // Encoding 3 on the request bus is reserved and never counts as a request.
  function automatic logic is_host_req(logic [1:0] req);
    return (req == EXT_RD) || (req == EXT_WR);
  endfunction

endpackage

// File: rtl/neuron_sweep_sched_if.sv
// Host access port of the sweep scheduler: request/address in, grant and strobes out.
interface neuron_sweep_sched_if #(
  parameter int AW = 8
) ();

  logic [1:0]    ext_req;
  logic [AW-1:0] ext_addr;
  logic          ext_grant;
  logic          ext_rd_en;
  logic          ext_wr_en;
  logic [AW-1:0] ext_addr_q;

  modport master (
    output ext_req,
    output ext_addr,
    input  ext_grant,
    input  ext_rd_en,
    input  ext_wr_en,
    input  ext_addr_q
  );

  modport slave (
    input  ext_req,
    input  ext_addr,
    output ext_grant,
    output ext_rd_en,
    output ext_wr_en,
    output ext_addr_q
  );

endinterface

// File: rtl/neuron_sweep_sched_addr_pipe.sv
// Valid/address delay line feeding the update (DEPTH-1) and write-back (DEPTH) stages.
module addr_pipe #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          src_valid,
  input  logic [AW-1:0] src_addr,
  output logic          mid_valid,
  output logic [AW-1:0] mid_addr,
  output logic          end_valid,
  output logic [AW-1:0] end_addr
);

  logic [DEPTH-1:0] valid_sr;
  logic [AW-1:0]    addr_sr [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_sr <= '0;
    end else begin
      valid_sr <= {valid_sr[DEPTH-2:0], src_valid};
    end
  end

  // Addresses are only meaningful alongside their valid bit, so they skip reset.
  always_ff @(posedge clk) begin
    addr_sr[0] <= src_addr;
    for (int i = 1; i < DEPTH; i++) begin
      addr_sr[i] <= addr_sr[i-1];
    end
  end

  assign mid_valid = valid_sr[DEPTH-2];
  assign mid_addr  = addr_sr[DEPTH-2];
  assign end_valid = valid_sr[DEPTH-1];
  assign end_addr  = addr_sr[DEPTH-1];

endmodule

// File: rtl/neuron_sweep_sched.sv
// Time-step scheduler: one read/update/write-back pass over every neuron per dt tick,
// with host access to the state RAMs granted only between sweeps.
module neuron_sweep_sched
  import neuron_pkg::*;
#(
  parameter int NEURON_NO  = NEURON_NO_DEF,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int AW         = $clog2(NEURON_NO)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sys_en,
  input  logic                       dt_tick,
  neuron_sweep_sched_if.slave        host,
  output logic                       rd_en,
  output logic [AW-1:0]              rd_addr,
  output logic                       upd_en,
  output logic [AW-1:0]              upd_addr,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic                       sweep_done,
  output logic                       busy,
  output logic                       overrun
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NEURON_NO - 1);

  sched_state_t  state;
  logic          pending;
  logic          start_sweep;
  logic          host_take;
  logic          upd_valid;
  logic          wr_valid;
  logic [AW-1:0] upd_addr_raw;
  logic [AW-1:0] wr_addr_raw;

  // A held request is ignored in its grant cycle, so it cannot be served twice in a row.
  assign start_sweep = sys_en && (dt_tick || pending);
  assign host_take   = is_host_req(host.ext_req) && !host.ext_grant;

  addr_pipe #(
    .AW    (AW),
    .DEPTH (PIPE_DEPTH)
  ) u_addr_pipe (
    .clk       (clk),
    .reset     (reset),
    .src_valid (rd_en),
    .src_addr  (rd_addr),
    .mid_valid (upd_valid),
    .mid_addr  (upd_addr_raw),
    .end_valid (wr_valid),
    .end_addr  (wr_addr_raw)
  );

  assign upd_en   = upd_valid;
  assign upd_addr = upd_valid ? upd_addr_raw : '0;
  assign wr_en    = wr_valid;
  assign wr_addr  = wr_valid ? wr_addr_raw : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      rd_en           <= 1'b0;
      rd_addr         <= '0;
      pending         <= 1'b0;
      overrun         <= 1'b0;
      sweep_done      <= 1'b0;
      busy            <= 1'b0;
      host.ext_grant  <= 1'b0;
      host.ext_rd_en  <= 1'b0;
      host.ext_wr_en  <= 1'b0;
      host.ext_addr_q <= '0;
    end else begin
      sweep_done     <= 1'b0;
      host.ext_grant <= 1'b0;
      host.ext_rd_en <= 1'b0;
      host.ext_wr_en <= 1'b0;

      case (state)
        IDLE: begin
          if (start_sweep) begin
            state   <= SWEEP;
            busy    <= 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= '0;
            // A fresh tick arriving together with a pended one stays pended.
            pending <= pending && dt_tick;
          end else if (host_take) begin
            host.ext_grant  <= 1'b1;
            host.ext_rd_en  <= (host.ext_req == EXT_RD);
            host.ext_wr_en  <= (host.ext_req == EXT_WR);
            host.ext_addr_q <= host.ext_addr;
          end
        end

        SWEEP: begin
          if (rd_addr == LAST_ADDR) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + 1'b1;
          end
        end

        DRAIN: begin
          if (wr_valid && (wr_addr_raw == LAST_ADDR)) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase

      // Ticks during a sweep queue one deep; anything beyond that is lost.
      if ((state != IDLE) && dt_tick) begin
        if (pending) begin
          overrun <= 1'b1;
        end else begin
          pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_neuron_sweep_sched.sv
// Scoreboard bench: a timeline model predicts every enable/grant event, a negedge monitor checks them.
module tb_neuron_sweep_sched;

  localparam int N  = 8;
  localparam int PD = 4;
  localparam int AW = $clog2(N);

  localparam int EV_RD   = 0;
  localparam int EV_UPD  = 1;
  localparam int EV_WR   = 2;
  localparam int EV_DONE = 3;
  localparam int EV_GNT  = 4;

  typedef struct {
    int cyc;
    int val;
  } evt_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          sys_en;
  logic          dt_tick;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          upd_en;
  logic [AW-1:0] upd_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          sweep_done;
  logic          busy;
  logic          overrun;

  neuron_sweep_sched_if #(.AW(AW)) hif ();

  neuron_sweep_sched #(
    .NEURON_NO  (N),
    .PIPE_DEPTH (PD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sys_en     (sys_en),
    .dt_tick    (dt_tick),
    .host       (hif),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .upd_en     (upd_en),
    .upd_addr   (upd_addr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .sweep_done (sweep_done),
    .busy       (busy),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int   checks      = 0;
  int   errors      = 0;
  int   cyc         = 0;
  int   done_cyc    = 0;
  int   start_cyc   = -1;
  int   last_grant  = -1;
  int   chk_zero_at = -1;
  bit   mon_on      = 1'b0;
  bit   pending_m   = 1'b0;
  bit   overrun_m   = 1'b0;
  evt_t evq [5][$];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push_evt(input int k, input int c, input int v);
    evt_t e;
    e.cyc = c;
    e.val = v;
    evq[k].push_back(e);
  endtask

  // Reference model: works on whole sweeps as time windows, evaluated on inputs sampled at cycle c.
  task automatic model_cycle(input int c);
    if (reset) begin
      for (int k = 0; k < 5; k++) evq[k].delete();
      pending_m   = 1'b0;
      overrun_m   = 1'b0;
      done_cyc    = c + 1;
      start_cyc   = -1;
      last_grant  = -1;
      chk_zero_at = c + 1;
      mon_on      = 1'b1;
      return;
    end
    if (c >= done_cyc) begin
      if (sys_en && (dt_tick || pending_m)) begin
        for (int i = 0; i < N; i++) begin
          push_evt(EV_RD,  c + 1 + i,      i);
          push_evt(EV_UPD, c + PD + i,     i);
          push_evt(EV_WR,  c + 1 + PD + i, i);
        end
        push_evt(EV_DONE, c + N + PD + 1, 0);
        start_cyc = c;
        done_cyc  = c + N + PD + 1;
        pending_m = pending_m && dt_tick;
      end else if ((hif.ext_req == 2'd1 || hif.ext_req == 2'd2) && last_grant != c) begin
        push_evt(EV_GNT, c + 1, int'({hif.ext_req == 2'd1, hif.ext_req == 2'd2, hif.ext_addr}));
        last_grant = c + 1;
      end
    end else if (dt_tick) begin
      if (pending_m) overrun_m = 1'b1;
      else pending_m = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit tick, input bit sys, input logic [1:0] req,
                               input logic [AW-1:0] addr, input bit rst);
    dt_tick      = tick;
    sys_en       = sys;
    hif.ext_req  = req;
    hif.ext_addr = addr;
    reset        = rst;
    @(posedge clk);
    model_cycle(cyc);
    cyc++;
    #1;
  endtask

  task automatic idle_cycles(input int n, input bit sys);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, sys, 2'd0, '0, 1'b0);
  endtask

  task automatic handle(input int k, input string name, input bit en, input int val);
    evt_t e;
    if (en) begin
      if (evq[k].size() == 0) begin
        checkOutput({name, "_unexpected"}, cyc, -1);
      end else begin
        e = evq[k].pop_front();
        checkOutput({name, "_cycle"}, cyc, e.cyc);
        checkOutput({name, "_value"}, val, e.val);
      end
    end else if (evq[k].size() != 0 && evq[k][0].cyc <= cyc) begin
      e = evq[k].pop_front();
      checkOutput({name, "_missing"}, -1, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (cyc == chk_zero_at) begin
        checkOutput("reset_zero",
                    int'({rd_en, upd_en, wr_en, sweep_done, busy, overrun, hif.ext_grant,
                          hif.ext_rd_en, hif.ext_wr_en, rd_addr, upd_addr, wr_addr, hif.ext_addr_q}), 0);
      end else begin
        checkOutput("busy", int'(busy), int'((cyc > start_cyc) && (cyc < done_cyc)));
        checkOutput("overrun", int'(overrun), int'(overrun_m));
      end
      handle(EV_RD,   "rd",    rd_en,         int'(rd_addr));
      handle(EV_UPD,  "upd",   upd_en,        int'(upd_addr));
      handle(EV_WR,   "wr",    wr_en,         int'(wr_addr));
      handle(EV_DONE, "done",  sweep_done,    0);
      handle(EV_GNT,  "grant", hif.ext_grant,
             int'({hif.ext_rd_en, hif.ext_wr_en, hif.ext_addr_q}));
      checkOutput("strobe_gate", int'({hif.ext_rd_en, hif.ext_wr_en} & {2{~hif.ext_grant}}), 0);
    end
  end

  logic [1:0]    cur_req;
  logic [AW-1:0] cur_addr;
  bit            sys;
  int            pick;

  initial begin
    applyStimulus(1'b0, 1'b1, 2'd0, '0, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, '0, 1'b1);
    idle_cycles(2, 1'b1);

    $display("[TB] host write in idle, held read, reserved request");
    applyStimulus(1'b0, 1'b1, 2'd2, AW'(5), 1'b0);
    idle_cycles(2, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 2'd1, AW'(2), 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 2'd3, AW'(7), 1'b0);
    idle_cycles(2, 1'b1);

    $display("[TB] tick ties with host read, pending tick, overrun tick");
    applyStimulus(1'b1, 1'b1, 2'd1, AW'(6), 1'b0);
    for (int k = 1; k < 60; k++) begin
      applyStimulus((k == 4) || (k == 6), 1'b1, 2'd1, AW'(6), 1'b0);
      if (last_grant == cyc) break;
    end
    idle_cycles(20, 1'b1);

    $display("[TB] reset in the middle of a sweep");
    applyStimulus(1'b1, 1'b1, 2'd0, '0, 1'b0);
    idle_cycles(2, 1'b1);
    applyStimulus(1'b0, 1'b1, 2'd0, '0, 1'b1);
    idle_cycles(20, 1'b1);

    $display("[TB] sys_en gating");
    applyStimulus(1'b1, 1'b0, 2'd0, '0, 1'b0);
    idle_cycles(3, 1'b0);
    applyStimulus(1'b1, 1'b1, 2'd0, '0, 1'b0);
    idle_cycles(2, 1'b1);
    for (int k = 0; k < 16; k++) applyStimulus(k == 5, 1'b0, 2'd0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 2'd2, AW'(3), 1'b0);
    idle_cycles(2, 1'b0);
    idle_cycles(16, 1'b1);

    $display("[TB] randomized traffic");
    sys      = 1'b1;
    cur_req  = 2'd0;
    cur_addr = '0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) sys = !sys;
      if (!(cur_req == 2'd1 || cur_req == 2'd2) || last_grant == cyc) begin
        pick     = int'($urandom_range(0, 9));
        cur_req  = (pick < 4) ? 2'(pick) : 2'd0;
        cur_addr = AW'($urandom_range(0, N - 1));
      end
      applyStimulus($urandom_range(0, 11) == 0, sys, cur_req, cur_addr,
                    $urandom_range(0, 249) == 0);
    end
    idle_cycles(40, 1'b1);

    for (int k = 0; k < 5; k++) checkOutput("leftover_events", evq[k].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_sweep_sched.md
# neuron_sweep_sched

Time-step scheduler for the time-multiplexed neuron datapath. On each `dt_tick` it sweeps every neuron address once through the read → update → write-back pipeline, issuing stage-aligned enables and addresses. It arbitrates host read/write access to the neuron state memories between sweeps. It sits between the dt counter and the neuron state RAMs / SRM update logic, and replaces ad-hoc enable generation.

## Interface
Parameters:
- `NEURON_NO`, 256, neurons per sweep (≥2)
- `PIPE_DEPTH`, 4, cycles from state read to write-back (≥2)
- `AW`, `$clog2(NEURON_NO)`, address width (derived)

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `sys_en`  in  1  permits new sweeps to start
- `dt_tick`  in  1  one-cycle time-step strobe
- `ext_req`  in  2  host request: 0 none, 1 read, 2 write, 3 ignored
- `ext_addr`  in  AW  host target address
- `ext_grant`  out  1  one-cycle grant pulse
- `ext_rd_en` / `ext_wr_en`  out  1  host access strobes, aligned with grant
- `ext_addr_q`  out  AW  registered host address, valid with grant
- `rd_en`, `rd_addr`  out  1/AW  stage 0: state RAM read
- `upd_en`, `upd_addr`  out  1/AW  stage PIPE_DEPTH-1: update/threshold
- `wr_en`, `wr_addr`  out  1/AW  stage PIPE_DEPTH: write-back
- `sweep_done`  out  1  pulse after the last write-back
- `busy`  out  1  high in SWEEP or DRAIN
- `overrun`  out  1  sticky: tick lost

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE → SWEEP on `dt_tick & sys_en`, or on pending tick with `sys_en`. Counter cleared to 0.
- SWEEP: one `rd_en` per cycle, `rd_addr` 0..NEURON_NO-1. After the last address → DRAIN.
- DRAIN: no new reads. Valid/address shift register drains. When the last address leaves stage PIPE_DEPTH: pulse `sweep_done`, go to IDLE.
- `upd_*` and `wr_*` are the delayed `rd_*` (PIPE_DEPTH-1 and PIPE_DEPTH cycles). Never asserted without a matching earlier read.
- Tick in SWEEP/DRAIN sets one-deep `pending`. Tick while `pending` already set sets `overrun` (sticky until reset); that tick is dropped.
- Tick with `sys_en` low in IDLE is ignored, not pended. `sys_en` falling mid-sweep does not abort; the sweep completes.
- Host arbitration: served only in IDLE, and only when no tick or pending-start occurs that cycle (sweep wins ties). `ext_req`=3 is never granted.
- Requests arriving in SWEEP/DRAIN wait; the requester holds `ext_req` until grant. `ext_req` still high the cycle after a grant is a new request.
- Counter wraps are impossible: terminal compare on NEURON_NO-1, not overflow.

## Timing
- Reset: every output 0. `state` IDLE, `pending`=0, `overrun`=0, pipeline valids 0. Reset mid-sweep kills all in-flight enables on the next edge.
- Tick sampled at cycle T (IDLE): `rd_en` on T+1..T+NEURON_NO; `upd_en` on T+PIPE_DEPTH..T+NEURON_NO+PIPE_DEPTH-1; `wr_en` on T+1+PIPE_DEPTH..T+NEURON_NO+PIPE_DEPTH.
- `sweep_done` at T+NEURON_NO+PIPE_DEPTH+1, same cycle as IDLE. `busy` high T+1..T+NEURON_NO+PIPE_DEPTH.
- Pending tick: treated as a tick sampled in the `sweep_done` cycle.
- Host: `ext_req`≠0 sampled at T in IDLE → grant/strobe/`ext_addr_q` at T+1. Back-to-back held request → grants every other cycle.

## Structure
- Package `neuron_pkg`:
  - `ext_req_t` enum (`EXT_NONE`, `EXT_RD`, `EXT_WR`)
  - `sched_state_t` enum (IDLE, SWEEP, DRAIN)
  - Shared default `NEURON_NO`
- Sub-module `addr_pipe` (params `AW`, `DEPTH`): valid+address shift register with taps at DEPTH-1 and DEPTH, synchronous reset on valids only.
- Top holds FSM, counter, pending/overrun, host arbiter.

## Test plan
- NEURON_NO=8, PIPE_DEPTH=4, tick at cycle 10 → `rd_addr` 0..7 cycles 11-18; `wr_addr` 0..7 cycles 15-22; `sweep_done` cycle 23.
- Second tick at cycle 14 → `pending`, new `rd_en` from cycle 24. Third tick at cycle 16 → `overrun`=1 and held.
- `ext_req`=2, addr 5 at cycle 3 → `ext_grant`, `ext_wr_en`, `ext_addr_q`=5 at cycle 4. Same request during sweep → grant at cycle 24.
- `dt_tick` and `ext_req`=1 both at cycle 10 → sweep starts, grant delayed to cycle after `sweep_done`. `ext_req`=3 → never granted.
- Reset at cycle 13 mid-sweep → all outputs 0 at cycle 14. No `wr_en` afterwards; `overrun` cleared.
- `sys_en`=0 with tick → no sweep, no pending. `sys_en` dropped at cycle 12 during sweep → sweep completes normally.
